// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, EMPTY/level tracking,
// RAM read issue and a 2-entry first-word-fall-through output buffer.
module fifo_rd_ctrl #(
    parameter int ADDRESS_BITS = 3,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    R_CLK,
    input  logic                    R_RST,
    input  logic [ADDRESS_BITS:0]   RQ2_WPTR,
    output logic [ADDRESS_BITS:0]   R_PTR,
    output logic [ADDRESS_BITS-1:0] R_ADDR,
    output logic                    R_EN,
    input  logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic [DATA_WIDTH-1:0]   DOUT,
    output logic                    DOUT_VALID,
    input  logic                    DOUT_READY,
    output logic                    EMPTY,
    output logic [ADDRESS_BITS:0]   R_LEVEL
);
    localparam int PW = ADDRESS_BITS + 1;

    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbin_next;
    logic [PW-1:0]         rgray_next;
    logic [PW-1:0]         wbin;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            credit;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign pop        = DOUT_VALID & DOUT_READY;
    assign DOUT_VALID = (occ != 2'd0);
    assign DOUT       = buf0;
    assign R_ADDR     = rbin[ADDRESS_BITS-1:0];

    // Buffer occupancy after this edge; issuing only while it is below 2
    // leaves room for the word that lands one cycle later.
    assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign R_EN       = !EMPTY && (credit < 3'd2);

    assign rbin_next  = rbin + {{ADDRESS_BITS{1'b0}}, R_EN};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign wbin       = gray2bin(RQ2_WPTR);

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rbin     <= '0;
            R_PTR    <= '0;
            EMPTY    <= 1'b1;
            R_LEVEL  <= '0;
            inflight <= 1'b0;
        end else begin
            rbin     <= rbin_next;
            R_PTR    <= rgray_next;
            EMPTY    <= (rgray_next == RQ2_WPTR);
            R_LEVEL  <= wbin - rbin_next;
            inflight <= R_EN;
        end
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            occ <= credit[1:0];
            case ({pop, inflight})
                2'b01: begin
                    if (occ == 2'd0) buf0 <= RD_DATA;
                    else             buf1 <= RD_DATA;
                end
                2'b10: buf0 <= buf1;
                2'b11: begin
                    // Head leaves first; the arriving word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        buf0 <= RD_DATA;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a sync-read RAM model, a word queue
// and issue/pop counters form the reference; directed plus random traffic.
module tb_fifo_rd_ctrl;
    localparam int AB    = 3;
    localparam int DW    = 8;
    localparam int PW    = AB + 1;
    localparam int DEPTH = 1 << AB;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] r_ptr;
    logic [AB-1:0] r_addr;
    logic          r_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          empty;
    logic [PW-1:0] r_level;

    always #5 r_clk = ~r_clk;

    fifo_rd_ctrl #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) dut (
        .R_CLK      (r_clk),
        .R_RST      (r_rst),
        .RQ2_WPTR   (rq2_wptr),
        .R_PTR      (r_ptr),
        .R_ADDR     (r_addr),
        .R_EN       (r_en),
        .RD_DATA    (rd_data),
        .DOUT       (dout),
        .DOUT_VALID (dout_valid),
        .DOUT_READY (dout_ready),
        .EMPTY      (empty),
        .R_LEVEL    (r_level)
    );

    logic [DW-1:0] mem [DEPTH];

    always @(posedge r_clk) begin
        if (r_en) rd_data <= mem[r_addr];
    end

    // Reference state: words written / issued / popped as plain counts.
    int            checks;
    int            errors;
    int            issued;
    int            popped;
    int            wcnt;
    int            wcnt_s;
    bit            inflight_m;
    bit            r_en_s;
    bit            pop_s;
    bit            empty_s;
    bit            valid_s;
    logic [DW-1:0] exp_q [$];

    int first_valid;
    int n_pops;
    int en_cnt;
    int start;
    int wr_left;
    bit found;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = n[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_q.push_back(d);
        wcnt++;
        rq2_wptr = gray(wcnt);
    endtask

    task automatic model_reset();
        issued     = 0;
        popped     = 0;
        wcnt       = 0;
        wcnt_s     = 0;
        inflight_m = 1'b0;
        exp_q.delete();
    endtask

    // One clock: check outputs at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        int occ_m;
        @(negedge r_clk);
        occ_m = issued - popped - int'(inflight_m);
        chk("empty", empty, issued == wcnt_s);
        chk("r_level", r_level, wcnt_s - issued);
        chk("r_ptr", r_ptr, gray(issued));
        chk("r_addr", r_addr, issued % DEPTH);
        chk("dout_valid", dout_valid, occ_m != 0);
        chk("occ_le_2", occ_m <= 2, 1);
        if (r_en) chk("r_en_while_empty", empty, 0);
        if (dout_valid) begin
            if (exp_q.size() == 0) chk("spurious_word", dout_valid, 0);
            else                   chk("dout", dout, exp_q[0]);
        end
        r_en_s  = r_en;
        pop_s   = dout_valid & dout_ready;
        empty_s = empty;
        valid_s = dout_valid;
        @(posedge r_clk);
        issued    += int'(r_en_s);
        popped    += int'(pop_s);
        inflight_m = r_en_s;
        wcnt_s     = wcnt;
        if (pop_s && exp_q.size() > 0) void'(exp_q.pop_front());
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        r_rst      = 1'b1;
        dout_ready = 1'b0;
        rq2_wptr   = '0;
        model_reset();
        repeat (2) @(posedge r_clk);
        #1;
        r_rst = 1'b0;

        // Idle after reset: nothing may move.
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t1_r_en", r_en_s, 0);
            chk("t1_valid", valid_s, 0);
        end

        // Full-depth burst with consumer always ready. Pointer visible in
        // cycle 0: EMPTY drops at edge 1, read at edge 2, capture at edge 3.
        dout_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_word(8'hA0 + 8'(i));
        first_valid = -1;
        n_pops      = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (valid_s && first_valid < 0) first_valid = c;
            if (pop_s) begin
                chk("t2_pop_slot", c, 3 + n_pops);
                n_pops++;
            end
        end
        chk("t2_first_valid", first_valid, 3);
        chk("t2_count", n_pops, DEPTH);
        chk("t2_empty_end", empty, 1);
        chk("t2_r_ptr_end", r_ptr, 4'b1100);

        // Same burst with consumer stalled: the buffer fills after two reads.
        dout_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(8'hA0 + 8'(i));
        en_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            en_cnt += int'(r_en_s);
        end
        chk("t3_r_en_pulses", en_cnt, 2);
        chk("t3_dout_held", dout, 8'hA0);
        chk("t3_level", r_level, 6);
        chk("t3_valid", dout_valid, 1);
        dout_ready = 1'b1;
        n_pops     = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (pop_s) begin
                chk("t3_pop_slot", c, n_pops);
                n_pops++;
            end
        end
        chk("t3_count", n_pops, DEPTH);

        // New word arrives on the same edge that issues the last one.
        for (int i = 0; i < 3; i++) write_word(8'h51 + 8'(i));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            if (r_en_s && issued == wcnt) found = 1'b1;
        end
        chk("t6_last_issue_seen", found, 1);
        write_word(8'h5F);
        cycle();
        chk("t6_empty_pulse", empty_s, 1);
        cycle();
        chk("t6_empty_drop", empty_s, 0);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cycle();
        chk("t6_drained", exp_q.size(), 0);

        // Random producer/consumer across pointer wraps.
        start   = popped;
        wr_left = 40;
        for (int c = 0; c < 3000 && popped - start < 40; c++) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (wr_left > 0 && wcnt - issued < DEPTH && $urandom_range(0, 2) != 0) begin
                write_word(8'($urandom));
                wr_left--;
            end
            cycle();
        end
        chk("t4_delivered", popped - start, 40);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Asynchronous reset with the buffer holding a word and a read in flight.
        dout_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(8'hC0 + 8'(i));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            if (inflight_m && (issued - popped - 1) >= 1) found = 1'b1;
        end
        chk("t5_state_reached", found, 1);
        #2;
        r_rst = 1'b1;
        #1;
        chk("t5_rst_valid", dout_valid, 0);
        chk("t5_rst_empty", empty, 1);
        chk("t5_rst_r_en", r_en, 0);
        chk("t5_rst_r_ptr", r_ptr, 0);
        chk("t5_rst_level", r_level, 0);
        chk("t5_rst_dout", dout, 0);
        chk("t5_rst_r_addr", r_addr, 0);
        rq2_wptr = '0;
        model_reset();
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        wcnt  = 3;
        rq2_wptr = gray(3);
        for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
        dout_ready = 1'b1;
        for (int c = 0; c < 20 && popped < 3; c++) cycle();
        for (int c = 0; c < 4; c++) cycle();
        chk("t5_words", popped, 3);
        chk("t5_empty_end", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
